dsi_lane_ctrl_multi: RTL



---
 rtl/dsi_lane_ctrl_multi.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dsi_lane_ctrl_multi.sv
// dsi_lane_ctrl_multi
//   LP/HS burst sequencer for a D-PHY link. Drives LANES data lanes in
//   lockstep (MODE=0) or one clock lane (MODE=1). Each timed state lasts
//   max(cfg,1) cycles, with cfg sampled on entry. HS_TRAIL gets one extra
//   leading cycle that carries the last data byte.
//
// Ports:
//   clk_sys          single clock, rising edge
//   rst              synchronous, active-high reset
//   start_rqst       request an HS burst (honoured in IDLE only)
//   fin_rqst         with data_rqst, marks the current byte as the last one
//   lane_en          per-lane enable, sampled when leaving IDLE
//   inp_data         lane i byte at [8i+7:8i]
//   cfg_t_*          state durations in clk_sys cycles
//   data_rqst        byte on inp_data consumed this cycle
//   active           sequencer is not in IDLE
//   hs_oe            per-lane HS driver enable
//   hs_data          per-lane parallel byte to the serializer
//   lp_p, lp_n       per-lane LP line levels
module dsi_lane_ctrl_multi #(
  parameter int          LANES     = 4,
  parameter int          MODE      = 0,
  parameter int          CNT_W     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 start_rqst,
  input  logic                 fin_rqst,
  input  logic [LANES-1:0]     lane_en,
  input  logic [8*LANES-1:0]   inp_data,
  input  logic [CNT_W-1:0]     cfg_t_lpx,
  input  logic [CNT_W-1:0]     cfg_t_hs_prep,
  input  logic [CNT_W-1:0]     cfg_t_hs_zero,
  input  logic [CNT_W-1:0]     cfg_t_hs_trail,
  input  logic [CNT_W-1:0]     cfg_t_hs_exit,
  output logic                 data_rqst,
  output logic                 active,
  output logic [LANES-1:0]     hs_oe,
  output logic [8*LANES-1:0]   hs_data,
  output logic [LANES-1:0]     lp_p,
  output logic [LANES-1:0]     lp_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HS_RQST,
    S_HS_PREP,
    S_HS_ZERO,
    S_HS_SYNC,
    S_HS_ACTIVE,
    S_HS_TRAIL,
    S_HS_EXIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 trail_first;   // first HS_TRAIL cycle (last data byte)
  logic [LANES-1:0]     mask;
  logic [8*LANES-1:0]   data_q;
  logic                 timeout;

  // Counter holds at 1 so cfg=0 and cfg=1 both give a one-cycle state.
  assign timeout   = !trail_first && (cnt <= ONE);
  assign data_rqst = (state == S_HS_ACTIVE);
  assign active    = (state != S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      trail_first <= 1'b0;
      mask        <= '0;
      data_q      <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        trail_first <= 1'b0;
        case (state_n)
          S_HS_RQST:  cnt <= cfg_t_lpx;
          S_HS_PREP:  cnt <= cfg_t_hs_prep;
          S_HS_ZERO:  cnt <= cfg_t_hs_zero;
          S_HS_TRAIL: begin
            cnt         <= cfg_t_hs_trail;
            trail_first <= 1'b1;
          end
          S_HS_EXIT:  cnt <= cfg_t_hs_exit;
          default:    cnt <= cnt;
        endcase
      end else if (trail_first) begin
        // Extra leading trail cycle: hold the counter so the configured
        // trail length follows it in full.
        trail_first <= 1'b0;
      end else if (cnt > ONE) begin
        cnt <= cnt - ONE;
      end

      if (state == S_IDLE && start_rqst)
        mask <= lane_en;

      // Preloading the sync byte lets HS_ACTIVE always output data_q,
      // giving the 1-cycle data latency with SYNC_BYTE in its first cycle.
      if (state == S_HS_SYNC)
        data_q <= {LANES{SYNC_BYTE}};
      else if (state == S_HS_ACTIVE)
        data_q <= inp_data;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (start_rqst) state_n = S_HS_RQST;
      S_HS_RQST:   if (timeout)    state_n = S_HS_PREP;
      S_HS_PREP:   if (timeout)    state_n = S_HS_ZERO;
      S_HS_ZERO:   if (timeout)    state_n = (MODE == 0) ? S_HS_SYNC : S_HS_ACTIVE;
      S_HS_SYNC:                   state_n = S_HS_ACTIVE;
      S_HS_ACTIVE: if (fin_rqst)   state_n = S_HS_TRAIL;
      S_HS_TRAIL:  if (timeout)    state_n = S_HS_EXIT;
      S_HS_EXIT:   if (timeout)    state_n = S_IDLE;
      default:                     state_n = S_IDLE;
    endcase
  end

  always_comb begin
    logic [7:0] b;
    logic [7:0] last;
    lp_p    = '1;
    lp_n    = '1;
    hs_oe   = '0;
    hs_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      b    = '0;
      last = data_q[8*i +: 8];
      case (state)
        S_HS_SYNC:   b = SYNC_BYTE;
        S_HS_ACTIVE: b = (MODE != 0) ? 8'h55 : last;
        // Clock lane: the leading trail cycle repeats the toggle pattern
        // as its "last byte"; the configured trail itself is zero.
        S_HS_TRAIL:
          if (trail_first) b = (MODE != 0) ? 8'h55 : last;
          else             b = (MODE != 0 || last[7]) ? 8'h00 : 8'hFF;
        default:     b = '0;
      endcase
      if (mask[i] && state != S_IDLE) begin
        case (state)
          S_HS_RQST: lp_p[i] = 1'b0;
          S_HS_PREP: begin
            lp_p[i] = 1'b0;
            lp_n[i] = 1'b0;
          end
          S_HS_ZERO, S_HS_SYNC, S_HS_ACTIVE, S_HS_TRAIL: begin
            lp_p[i]           = 1'b0;
            lp_n[i]           = 1'b0;
            hs_oe[i]          = 1'b1;
            hs_data[8*i +: 8] = b;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
